// File: rtl/pool_pkg.sv
// Shared types and geometry helpers for the 2x2 max-pooling controller.
// Holds the FSM state enum, map-size functions and argmax encodings.
package pool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_NEXT,
        ST_FIN
    } state_t;

    // Argmax position inside a 2x2 window.
    localparam logic [1:0] HIST_TL = 2'd0;
    localparam logic [1:0] HIST_TR = 2'd1;
    localparam logic [1:0] HIST_BL = 2'd2;
    localparam logic [1:0] HIST_BR = 2'd3;

    function automatic int size_of(input int n);
        return 2 * n;
    endfunction

    // Each input row is streamed as SIZE columns plus two repeats
    // of the last column, one per pooling-unit pass.
    function automatic int beats_per_row(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int beats_per_ch(input int n);
        return size_of(n) * beats_per_row(n);
    endfunction

endpackage

// File: rtl/pool_ctrl_addr_gen.sv
// Row/beat counters and feature-map read address for one channel.
// Ports: clk, rst_n, clr, step, ch -> addr, last_beat.
module pool_ctrl_addr_gen
    import pool_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = 10,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          step,
    input  logic [CW-1:0] ch,
    output logic [AW-1:0] addr,
    output logic          last_beat
);

    localparam int SIZE = size_of(N);
    localparam int BPR  = beats_per_row(N);
    localparam int RW   = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int BW   = $clog2(BPR);

    logic [RW-1:0] row;
    logic [BW-1:0] beat;
    logic [BW-1:0] col;
    logic          row_end;

    assign row_end   = (beat == BW'(BPR - 1));
    assign last_beat = row_end && (row == RW'(SIZE - 1));

    // Beats past the last column re-read the last column.
    assign col = (beat >= BW'(SIZE)) ? BW'(SIZE - 1) : beat;

    assign addr = AW'(ch) * AW'(SIZE * SIZE)
                + AW'(row) * AW'(SIZE)
                + AW'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            beat <= '0;
        end else if (clr) begin
            row  <= '0;
            beat <= '0;
        end else if (step) begin
            if (row_end) begin
                beat <= '0;
                row  <= last_beat ? '0 : row + 1'b1;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_ctrl.sv
// Sequencer streaming CH feature maps into the pooling unit and
// capturing pooled results into the output SRAM.
// Ports: start/busy/done handshake, fm_rd_* read port, pl_* pooling
// unit link, out_wr_* write port, out_idx argmax (POOL_CTRL_HIST_EN).
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int N  = 3,
    parameter int CH = 4,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fm_rd_en,
    output logic [AW-1:0] fm_rd_addr,
    input  logic [15:0]   fm_rd_data,
    output logic          pl_load,
    output logic [15:0]   pl_in,
    input  logic [15:0]   pl_result,
    input  logic [2:0]    pl_history,
    input  logic [5:0]    pl_addr,
    input  logic          pl_reg_sig,
    input  logic          pl_done,
    output logic          out_wr_en,
    output logic [AW-1:0] out_wr_addr,
    output logic [15:0]   out_wr_data
`ifdef POOL_CTRL_HIST_EN
    ,
    output logic [1:0]    out_idx
`endif
);

    localparam int SIZE = size_of(N);
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;

    if (CH * SIZE * SIZE > (1 << AW)) begin : g_aw_check
        $error("pool_ctrl: CH*SIZE*SIZE does not fit in AW bits");
    end

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] ch;
    logic          last_ch;
    logic          last_beat;
    logic [AW-1:0] gen_addr;
    logic          wr;
    logic          unused_hist;

    assign last_ch = (ch == CW'(CH - 1));

    pool_ctrl_addr_gen #(
        .N  (N),
        .AW (AW),
        .CW (CW)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       ((state == ST_IDLE) || (state == ST_NEXT)),
        .step      (state == ST_LOAD),
        .ch        (ch),
        .addr      (gen_addr),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_LOAD;
            ST_LOAD:  if (last_beat) state_nx = ST_DRAIN;
            ST_DRAIN: if (pl_done) state_nx = last_ch ? ST_FIN : ST_NEXT;
            ST_NEXT:  state_nx = ST_LOAD;
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0;
        end else if (state == ST_IDLE) begin
            ch <= '0;
        end else if (state == ST_NEXT) begin
            ch <= ch + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pl_load <= 1'b0;
        else        pl_load <= fm_rd_en;
    end

    assign pl_in = pl_load ? fm_rd_data : 16'h0000;

    // Writes are combinational from the pooling unit so a result
    // arriving with pl_done is still captured before the transition.
    always_comb begin
        busy        = (state != ST_IDLE);
        done        = (state == ST_FIN);
        fm_rd_en    = (state == ST_LOAD);
        fm_rd_addr  = fm_rd_en ? gen_addr : '0;
        wr          = (state == ST_DRAIN) && pl_reg_sig;
        out_wr_en   = wr;
        out_wr_addr = '0;
        out_wr_data = 16'h0000;
        if (wr) begin
            out_wr_addr = AW'(ch) * AW'(N * N) + AW'(pl_addr);
            out_wr_data = pl_result;
        end
    end

`ifdef POOL_CTRL_HIST_EN
    assign out_idx     = wr ? pl_history[1:0] : 2'b00;
    assign unused_hist = pl_history[2];
`else
    assign unused_hist = ^pl_history;
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl with a behavioural pooling unit
// and SRAM model; expected writes come from a direct 2x2 max model.
module tb_pool_ctrl;
    import pool_pkg::*;

    localparam int N   = 3;
    localparam int CH  = 4;
    localparam int AW  = 10;
    localparam int SZ  = 2 * N;
    localparam int BPR = SZ + 2;
    localparam int BPC = SZ * BPR;
    localparam int NW  = CH * N * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, fm_rd_en, pl_load;
    logic [AW-1:0] fm_rd_addr, out_wr_addr;
    logic [15:0]   fm_rd_data, pl_in, pl_result, out_wr_data;
    logic [2:0]    pl_history;
    logic [5:0]    pl_addr;
    logic          pl_reg_sig, pl_done, out_wr_en;
`ifdef POOL_CTRL_HIST_EN
    logic [1:0]    out_idx;
`endif

    int checks = 0;
    int failures = 0;

    pool_ctrl #(.N(N), .CH(CH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .fm_rd_en    (fm_rd_en),
        .fm_rd_addr  (fm_rd_addr),
        .fm_rd_data  (fm_rd_data),
        .pl_load     (pl_load),
        .pl_in       (pl_in),
        .pl_result   (pl_result),
        .pl_history  (pl_history),
        .pl_addr     (pl_addr),
        .pl_reg_sig  (pl_reg_sig),
        .pl_done     (pl_done),
        .out_wr_en   (out_wr_en),
        .out_wr_addr (out_wr_addr),
        .out_wr_data (out_wr_data)
`ifdef POOL_CTRL_HIST_EN
        ,
        .out_idx     (out_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feature-map SRAM: one-cycle read latency.
    logic [15:0] mem [0:CH*SZ*SZ-1];
    always @(posedge clk)
        if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];

    // Behavioural pooling unit: buffers one channel of beats, then
    // emits N*N results, pl_done on the last one.
    logic [15:0] lbuf [0:BPC-1];
    int  lcnt, ecnt;
    bit  emitting;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt <= 0; ecnt <= 0; emitting <= 0;
        end else begin
            if (pl_load) begin
                lbuf[lcnt] <= pl_in;
                if (lcnt == BPC - 1) begin
                    lcnt <= 0; emitting <= 1; ecnt <= 0;
                end else lcnt <= lcnt + 1;
            end
            if (emitting) begin
                if (ecnt == N * N - 1) emitting <= 0;
                ecnt <= ecnt + 1;
            end
        end
    end

    always_comb begin
        logic [15:0] best;
        logic [15:0] p;
        int i, j;
        pl_reg_sig = emitting;
        pl_done    = emitting && (ecnt == N * N - 1);
        pl_addr    = 6'(ecnt);
        pl_result  = 16'h0;
        pl_history = 3'b0;
        best       = 16'h0;
        p          = 16'h0;
        i          = ecnt / N;
        j          = ecnt % N;
        if (emitting) begin
            for (int q = 0; q < 4; q++) begin
                p = lbuf[(2 * i + q / 2) * BPR + 2 * j + q % 2];
                if (q == 0 || p > best) begin
                    best = p;
                    pl_history = 3'(q);
                end
            end
            pl_result = best;
        end
    end

    // Reference results straight from the map contents.
    logic [15:0] exp_data [0:NW-1];
    logic [1:0]  exp_idx  [0:NW-1];
    logic [15:0] wr_log   [0:NW-1];

    task automatic build_ref();
        logic [15:0] p;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    int k;
                    k = c * N * N + i * N + j;
                    exp_data[k] = 16'h0;
                    exp_idx[k]  = HIST_TL;
                    for (int q = 0; q < 4; q++) begin
                        p = mem[c * SZ * SZ + (2 * i + q / 2) * SZ
                                + 2 * j + q % 2];
                        if (q == 0 || p > exp_data[k]) begin
                            exp_data[k] = p;
                            exp_idx[k]  = 2'(q);
                        end
                    end
                end
    endtask

    function automatic int exp_rd(input int k);
        int c, r, b;
        c = k / BPC;
        r = (k % BPC) / BPR;
        b = k % BPR;
        return c * SZ * SZ + r * SZ + ((b > SZ - 1) ? SZ - 1 : b);
    endfunction

    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    bit prev_en = 0, prev_pl_done = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fm_rd_en) begin
                check("rd_addr", 32'(fm_rd_addr), 32'(exp_rd(rd_cnt)));
                rd_cnt++;
            end
            check("pl_load_delay", 32'(pl_load), 32'(prev_en));
            if (pl_load) check("pl_in", 32'(pl_in), 32'(fm_rd_data));
            if (out_wr_en) begin
                if (wr_cnt < NW) begin
                    check("wr_addr", 32'(out_wr_addr), 32'(wr_cnt));
                    check("wr_data", 32'(out_wr_data), 32'(exp_data[wr_cnt]));
`ifdef POOL_CTRL_HIST_EN
                    check("wr_idx", 32'(out_idx), 32'(exp_idx[wr_cnt]));
`endif
                    wr_log[wr_cnt] = out_wr_data;
                end else begin
                    check("wr_overflow", 32'(wr_cnt), 32'(NW - 1));
                end
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                check("done_after_pl_done", 32'(prev_pl_done), 32'd1);
            end
            prev_en      = fm_rd_en;
            prev_pl_done = pl_done;
        end else begin
            prev_en      = 0;
            prev_pl_done = 0;
        end
    end

    task automatic chk_idle(input string tag);
        logic [31:0] v;
        v = {busy, done, fm_rd_en, pl_load, out_wr_en};
`ifdef POOL_CTRL_HIST_EN
        v = v | 32'(out_idx);
`endif
        check({tag, "_flags"}, v, 32'd0);
        check({tag, "_addrs"}, 32'(fm_rd_addr) | 32'(out_wr_addr), 32'd0);
        check({tag, "_data"}, {pl_in, out_wr_data}, 32'd0);
    endtask

    task automatic clear_counts();
        @(posedge clk); #1;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    endtask

    task automatic run_layer(input bit pulse);
        int cyc;
        bit seen;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check("busy_k1", 32'(busy), 32'd1);
        check("rd_en_k1", 32'(fm_rd_en), 32'd1);
        check("pl_load_k1", 32'(pl_load), 32'd0);
        @(negedge clk);
        check("pl_load_k2", 32'(pl_load), 32'd1);
        cyc  = 2;
        seen = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = pulse && (cyc == 12 || cyc == 57);
            if (done) seen = 1;
        end
        start = 0;
        check("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_single", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("rd_count", 32'(rd_cnt), 32'(CH * BPC));
        check("wr_count", 32'(wr_cnt), 32'(NW));
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int ramp_exp [0:8];
        int n;
        ramp_exp = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
        rst_n = 0;
        start = 0;
        for (int a = 0; a < CH * SZ * SZ; a++) mem[a] = 16'($urandom);
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        rst_n = 1;
        repeat (10) begin
            @(negedge clk);
            chk_idle("idle_no_start");
        end

        // Ramp map: each pooled value is the bottom-right pixel.
        for (int a = 0; a < CH * SZ * SZ; a++) mem[a] = 16'(a);
        build_ref();
        clear_counts();
        run_layer(0);
        for (int k = 0; k < 9; k++)
            check("ramp_ch0", 32'(wr_log[k]), 32'(ramp_exp[k]));

        // Random map with start pulses during LOAD and DRAIN.
        for (int a = 0; a < CH * SZ * SZ; a++) mem[a] = 16'($urandom);
        build_ref();
        clear_counts();
        run_layer(1);

        // Reset at beat 20 of channel 1, then a clean rerun.
        for (int a = 0; a < CH * SZ * SZ; a++) mem[a] = 16'($urandom);
        build_ref();
        clear_counts();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        n = 0;
        while (rd_cnt < BPC + 20 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_beat20", 32'(rd_cnt), 32'(BPC + 20));
        rst_n = 0;
        #1;
        chk_idle("reset_now");
        @(negedge clk);
        chk_idle("reset_next");
        clear_counts();
        rst_n = 1;
        run_layer(0);

        // All-equal map: first window position wins ties.
        for (int a = 0; a < CH * SZ * SZ; a++) mem[a] = 16'd5;
        build_ref();
        clear_counts();
        run_layer(0);
        check("tie_data0", 32'(wr_log[0]), 32'd5);
        check("tie_dataN", 32'(wr_log[NW-1]), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
